div_iter_param: RTL and testbench
=================================

Name: div_iter_param

Overview:
Parametrised iterative integer divider. It is the next-generation replacement for the single-radix 64-bit divider in the execute stage. It generalises operand width and the number of quotient bits retired per cycle, carries a tag for out-of-order writeback, and adds output back-pressure, pipeline flush and RISC-V corner-case results. It sits behind the issue queue and drives the writeback arbiter through a valid/ready pair.

Parameters:
XLEN, 64, operand/result width; legal values 32 or 64.
BPC, 1, quotient bits per cycle (unrolled restoring steps); legal 1, 2, 4; must divide 32.
TAG_W, 6, width of the request tag (ROB index).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  divider can accept a request
req_op  in  3  [0]=unsigned, [1]=remainder, [2]=word (32-bit op; legal only when XLEN=64, ignored when XLEN=32)
req_a  in  XLEN  dividend
req_b  in  XLEN  divisor
req_tag  in  TAG_W  tag, returned unchanged
flush  in  1  kill any in-flight operation
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_result  out  XLEN  quotient or remainder
resp_tag  out  TAG_W  tag of the result

Behaviour:
- Reset values: resp_valid=0, resp_result=0, resp_tag=0, state=IDLE. req_ready is combinational (1 in IDLE after reset).
- States: IDLE, CALC, OUTPUT.
- req_ready = (state==IDLE) && !flush.
- Accept occurs on a rising edge with req_valid && req_ready.
- On accept, register the following:
  - Operand magnitudes, after sign- or zero-extension of bits [31:0] for word ops.
  - Signs (forced 0 when unsigned).
  - Op and tag.
  - Iteration count: N/BPC-1, where N=32 for word ops, otherwise XLEN.
  - State goes to CALC.
- CALC performs BPC restoring steps per cycle, MSB-first:
  - rem_shift = {rem, next dividend bit}.
  - If rem_shift >= b, then rem = rem_shift - b and the quotient bit is 1; otherwise rem = rem_shift and the quotient bit is 0.
- When the count reaches 0, the CALC cycle registers the final signed result into resp_result:
  - Quotient negated if sign_a ^ sign_b and b != 0.
  - Remainder negated if sign_a.
  - Word results sign-extended from bit 31.
  - resp_valid is set and state goes to OUTPUT.
- Latency: resp_valid rises N/BPC+1 edges after the accept edge. Examples: 65 for XLEN=64, BPC=1; 17 for word ops with BPC=2.
- OUTPUT:
  - resp_valid, resp_result and resp_tag are held stable until resp_valid && resp_ready.
  - On that edge, resp_valid goes to 0 and state goes to IDLE.
  - A new request can be accepted on the following cycle at the earliest.
- Divide by zero: quotient = all ones (-1), remainder = dividend. For word ops both results are sign-extended from 32 bits. This falls out of the restoring algorithm; no sign fix is applied to the quotient.
- Signed overflow (a = most negative value, b = -1): quotient = a, remainder = 0. This also falls out of magnitude arithmetic with wrap-around negation.
- Flush: on an edge with flush=1, from any state:
  - State goes to IDLE and resp_valid goes to 0.
  - The in-flight result is discarded; no request is accepted on that edge.
- rst behaves like flush and additionally clears resp_result and resp_tag. rst has priority over every other event.
- Operations with resp_ready held 0 stall indefinitely in OUTPUT; no data loss.

Optional Feature:
DIV_EARLY_OUT_EN
- Defined: the divider takes a fast path when the divisor is zero or |a| < |b|. On the accept edge it computes the result directly: divide-by-zero per the rules above; quotient 0 / remainder a when |a| < |b|. It goes straight to OUTPUT, with resp_valid high 1 edge after accept.
- Undefined: every operation takes the full N/BPC+1 latency. Results are identical either way.

Decomposition:
- Package div_pkg holds:
  - op bit positions DIV_OP_UNSIGNED=0, DIV_OP_REM=1, DIV_OP_WORD=2;
  - the state enum (IDLE, CALC, OUTPUT);
  - localparam helpers for the iteration count.
- Sub-module div_step: combinational single restoring step (rem_in, dividend bit, divisor -> rem_out, quotient bit). The top instantiates BPC copies in a chain via generate.

Test Plan:
1. XLEN=64, BPC=1, op=000 (DIV), a=-20, b=3, resp_ready=1 -> resp_result=-6 with the given tag, exactly 65 edges after accept; op=010 (REM) -> -2.
2. op=001 (DIVU), a=0xFFFF_FFFF_FFFF_FFFF, b=0 -> result 0xFFFF_FFFF_FFFF_FFFF; op=011 (REMU) -> a unchanged.
3. op=000, a=0x8000_0000_0000_0000, b=-1 -> 0x8000_0000_0000_0000; op=010 -> 0. Word op=100, a=0x8000_0000, b=-1 -> 0xFFFF_FFFF_8000_0000.
4. BPC=4, op=100 (DIVW), a=0x0000_0000_7FFF_FFFF, b=7 -> 0x0000_0000_1249_2492 after 9 edges.
5. resp_ready held 0 for 10 cycles after resp_valid -> result/tag stable and req_ready=0. One-cycle resp_ready -> resp_valid drops, req_ready=1 next cycle.
6. Flush asserted at CALC cycle 20 with req_valid=1 -> no resp_valid, req_ready=0 that cycle and 1 the next. A following DIVU 100/7 returns 14 and is not corrupted. Repeat with rst mid-CALC; with DIV_EARLY_OUT_EN, 3/5 returns 0 one edge after accept.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: op-field bit positions,
// FSM state encoding and iteration-count helpers.
package div_pkg;

  localparam int DIV_OP_UNSIGNED = 0;
  localparam int DIV_OP_REM      = 1;
  localparam int DIV_OP_WORD     = 2;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    OUTPUT
  } div_state_t;

  // Value loaded into the step counter: one cycle per BPC quotient bits.
  function automatic int unsigned div_iter_count(input int unsigned n, input int unsigned bpc);
    return n / bpc - 1;
  endfunction

  // Counter width large enough to hold div_iter_count(xlen, bpc).
  function automatic int unsigned div_cnt_w(input int unsigned xlen, input int unsigned bpc);
    return $clog2(xlen / bpc);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in the next dividend bit and
// subtract the divisor when it fits.
module div_step #(
  parameter int W = 64
) (
  input  logic [W-1:0] rem_in,
  input  logic         dividend_bit,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic         quo_bit
);

  logic [W:0] rem_shift;
  logic [W:0] diff;

  // NOTE: every output of an always_comb gets a value on every path, so no latch can be inferred.
  always_comb begin
    rem_shift = {rem_in, dividend_bit};
    diff      = rem_shift - {1'b0, divisor};
    quo_bit   = (rem_shift >= {1'b0, divisor});
    rem_out   = quo_bit ? diff[W-1:0] : rem_shift[W-1:0];
  end

endmodule

// File: rtl/div_iter_param.sv
// Parametrised iterative restoring divider with tag, back-pressure and flush.
// Optional macro DIV_EARLY_OUT_EN adds a one-cycle path for b == 0 or |a| < |b|.
module div_iter_param
  import div_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int BPC   = 1,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_result,
  output logic [TAG_W-1:0] resp_tag
);

  localparam int CNT_W = div_cnt_w(XLEN, BPC);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(div_iter_count(XLEN, BPC));
  localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(div_iter_count(32, BPC));

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = '0;
    r[31:0] = v;
    return r;
  endfunction

  div_state_t       state;
  logic [XLEN-1:0]  dividend;
  logic [XLEN-1:0]  divisor;
  logic [XLEN-1:0]  rem;
  logic [XLEN-1:0]  quo;
  logic             sign_a;
  logic             sign_b;
  logic             op_rem;
  logic             op_word;
  logic             steps_done;
  logic [CNT_W-1:0] count;

  logic             req_word;
  logic             req_unsigned;
  logic [XLEN-1:0]  a_ext;
  logic [XLEN-1:0]  b_ext;
  logic [XLEN-1:0]  a_mag;
  logic [XLEN-1:0]  b_mag;
  logic             a_neg;
  logic             b_neg;

  logic [XLEN-1:0]  rem_chain [0:BPC];
  logic [BPC-1:0]   quo_bits;
  logic [XLEN-1:0]  quo_fix;
  logic [XLEN-1:0]  rem_fix;
  logic [XLEN-1:0]  result;

  assign req_ready = (state == IDLE) && !flush;

  // Word ops only exist on a 64-bit datapath.
  always_comb begin
    req_word     = (XLEN == 64) && req_op[DIV_OP_WORD];
    req_unsigned = req_op[DIV_OP_UNSIGNED];
    a_ext        = req_a;
    b_ext        = req_b;
    if (req_word) begin
      a_ext = req_unsigned ? zext32(req_a[31:0]) : sext32(req_a[31:0]);
      b_ext = req_unsigned ? zext32(req_b[31:0]) : sext32(req_b[31:0]);
    end
    a_neg = !req_unsigned && a_ext[XLEN-1];
    b_neg = !req_unsigned && b_ext[XLEN-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
  end

  assign rem_chain[0] = rem;

  for (genvar i = 0; i < BPC; i++) begin : g_step
    div_step #(.W(XLEN)) u_step (
      .rem_in       (rem_chain[i]),
      .dividend_bit (dividend[XLEN-1-i]),
      .divisor      (divisor),
      .rem_out      (rem_chain[i+1]),
      .quo_bit      (quo_bits[BPC-1-i])
    );
  end

  // Sign fix-up; a zero divisor leaves the all-ones quotient untouched.
  always_comb begin
    quo_fix = ((sign_a ^ sign_b) && (divisor != '0)) ? -quo : quo;
    rem_fix = sign_a ? -rem : rem;
    result  = op_rem ? rem_fix : quo_fix;
    if (op_word) result = sext32(result[31:0]);
  end

  // NOTE: only control state and the response registers are reset; the
  // datapath registers are always loaded on accept before they are read.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      resp_valid  <= 1'b0;
      resp_result <= '0;
      resp_tag    <= '0;
    end else if (flush) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            // Word dividends are left-aligned so the MSB-first walk starts at bit 31.
            dividend   <= req_word ? (a_mag << 32) : a_mag;
            divisor    <= b_mag;
            rem        <= '0;
            quo        <= '0;
            sign_a     <= a_neg;
            sign_b     <= b_neg;
            op_rem     <= req_op[DIV_OP_REM];
            op_word    <= req_word;
            resp_tag   <= req_tag;
            count      <= req_word ? CNT_WORD : CNT_FULL;
            steps_done <= 1'b0;
            state      <= CALC;
`ifdef DIV_EARLY_OUT_EN
            // Trivial cases skip the steps and go straight to the fix-up cycle.
            if ((b_mag == '0) || (a_mag < b_mag)) begin
              quo        <= (b_mag == '0) ? '1 : '0;
              rem        <= a_mag;
              steps_done <= 1'b1;
            end
`endif
          end
        end
        CALC: begin
          if (!steps_done) begin
            dividend <= dividend << BPC;
            rem      <= rem_chain[BPC];
            quo      <= {quo[XLEN-BPC-1:0], quo_bits};
            if (count == '0) steps_done <= 1'b1;
            else             count      <= count - 1'b1;
          end else begin
            resp_result <= result;
            resp_valid  <= 1'b1;
            state       <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter_param.sv
// Self-checking bench for div_iter_param: arithmetic reference model,
// per-cycle handshake/result compare, directed corner cases and random traffic.
module tb_div_iter_param;

  localparam int XLEN  = 64;
  localparam int BPC   = 1;
  localparam int TAG_W = 6;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [XLEN-1:0]  req_a;
  logic [XLEN-1:0]  req_b;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             resp_valid;
  logic             resp_ready;
  logic [XLEN-1:0]  resp_result;
  logic [TAG_W-1:0] resp_tag;

  div_iter_param #(.XLEN(XLEN), .BPC(BPC), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_tag     (req_tag),
    .flush       (flush),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_tag    (resp_tag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0]      result;
    logic [TAG_W-1:0] tag;
    int               due;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   checking = 1'b0;
  bit   rand_bp  = 1'b0;

  // RISC-V M-extension semantics in plain arithmetic; op = {word, rem, unsigned}.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [31:0] r32;
    logic [63:0] r;
    int          sa32, sb32;
    longint      sa, sb;
    if (op[2]) begin
      sa32 = a[31:0];
      sb32 = b[31:0];
      if (b[31:0] == 32'h0)                                  r32 = op[1] ? a[31:0] : 32'hFFFF_FFFF;
      else if (op[0])                                        r32 = op[1] ? a[31:0] % b[31:0] : a[31:0] / b[31:0];
      else if (a[31:0] == 32'h8000_0000 && b[31:0] == '1)    r32 = op[1] ? 32'h0 : a[31:0];
      else                                                   r32 = op[1] ? sa32 % sb32 : sa32 / sb32;
      r = {{32{r32[31]}}, r32};
    end else begin
      sa = a;
      sb = b;
      if (b == 64'h0)                   r = op[1] ? a : '1;
      else if (op[0])                   r = op[1] ? a % b : a / b;
      else if (a == MIN64 && b == '1)   r = op[1] ? 64'h0 : a;
      else                              r = op[1] ? sa % sb : sa / sb;
    end
    return r;
  endfunction

  function automatic int op_latency(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
`ifdef DIV_EARLY_OUT_EN
    logic [63:0] ae, be, am, bm;
    ae = op[2] ? (op[0] ? {32'h0, a[31:0]} : {{32{a[31]}}, a[31:0]}) : a;
    be = op[2] ? (op[0] ? {32'h0, b[31:0]} : {{32{b[31]}}, b[31:0]}) : b;
    am = (!op[0] && ae[63]) ? -ae : ae;
    bm = (!op[0] && be[63]) ? -be : be;
    if (bm == 64'h0 || am < bm) return 1;
`endif
    return (op[2] ? 32 : XLEN) / BPC + 1;
  endfunction

  function automatic logic [63:0] rand_operand();
    logic [63:0] v;
    case ($urandom_range(0, 6))
      0:       v = '0;
      1:       v = '1;
      2:       v = MIN64;
      3:       v = 64'h0000_0000_8000_0000;
      4:       v = 64'($urandom_range(0, 15));
      5:       v = {$urandom, $urandom};
      default: v = {32'h0, $urandom} >> $urandom_range(0, 31);
    endcase
    if ($urandom_range(0, 3) == 0) v = -v;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_bp) resp_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Runs beside the driver; outputs sampled at the falling edge.
  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (checking) begin
        check("req_ready", 64'(req_ready), 64'(expq.size() == 0 && !flush));
        if (expq.size() == 0) begin
          check("resp_valid_idle", 64'(resp_valid), 64'h0);
        end else begin
          check("resp_valid", 64'(resp_valid), 64'(cyc >= expq[0].due));
          if (resp_valid) begin
            check("resp_result", resp_result, expq[0].result);
            check("resp_tag", 64'(resp_tag), 64'(expq[0].tag));
            if (resp_ready) void'(expq.pop_front());
          end
        end
      end
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [TAG_W-1:0] tag);
    exp_t e;
    bit   ok;
    ok        = 1'b0;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
      tick();
    end
    req_valid = 1'b0;
    if (!ok) begin
      fail("req_accept");
    end else begin
      e.result = model(op, a, b);
      e.tag    = tag;
      e.due    = cyc + op_latency(op, a, b);
      expq.push_back(e);
    end
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles && expq.size() != 0; i++) tick();
    if (expq.size() != 0) begin
      fail("resp_wait");
      expq.delete();
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    flush      = 1'b0;
    resp_ready = 1'b1;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    req_tag    = '0;
    fork
      compare_loop();
    join_none

    // Hand-computed values that pin the reference model.
    check("pin_div",       model(3'b000, -64'd20, 64'd3), -64'd6);
    check("pin_rem",       model(3'b010, -64'd20, 64'd3), -64'd2);
    check("pin_divu_z",    model(3'b001, '1, 64'd0), 64'hFFFF_FFFF_FFFF_FFFF);
    check("pin_remu_z",    model(3'b011, 64'h123, 64'd0), 64'h123);
    check("pin_div_ovf",   model(3'b000, MIN64, '1), MIN64);
    check("pin_rem_ovf",   model(3'b010, MIN64, '1), 64'h0);
    check("pin_divw_ovf",  model(3'b100, 64'h8000_0000, '1), 64'hFFFF_FFFF_8000_0000);
    check("pin_divw",      model(3'b100, 64'h7FFF_FFFF, 64'd7), 64'h1249_2492);
    check("pin_divu",      model(3'b001, 64'd100, 64'd7), 64'd14);
    check("pin_small",     model(3'b000, 64'd3, 64'd5), 64'd0);

    repeat (3) tick();
    check("rst_resp_valid",  64'(resp_valid), 64'h0);
    check("rst_resp_result", resp_result, 64'h0);
    check("rst_resp_tag",    64'(resp_tag), 64'h0);
    check("rst_req_ready",   64'(req_ready), 64'h1);
    rst      = 1'b0;
    checking = 1'b1;

    // Directed corner cases.
    issue(3'b000, -64'd20, 64'd3, 6'd5);              wait_idle(200);
    issue(3'b010, -64'd20, 64'd3, 6'd6);              wait_idle(200);
    issue(3'b001, '1, 64'd0, 6'd7);                   wait_idle(200);
    issue(3'b011, '1, 64'd0, 6'd8);                   wait_idle(200);
    issue(3'b000, MIN64, '1, 6'd9);                   wait_idle(200);
    issue(3'b010, MIN64, '1, 6'd10);                  wait_idle(200);
    issue(3'b100, 64'h8000_0000, '1, 6'd11);          wait_idle(200);
    issue(3'b100, 64'h7FFF_FFFF, 64'd7, 6'd12);       wait_idle(200);
    issue(3'b110, 64'hDEAD_0000_8000_0001, 64'd0, 6'd13); wait_idle(200);

    // Back-pressure: result and tag must hold while resp_ready is low.
    resp_ready = 1'b0;
    issue(3'b000, 64'd1_000_003, -64'd17, 6'd21);
    for (int i = 0; i < 200 && !resp_valid; i++) tick();
    if (!resp_valid) fail("bp_resp_valid");
    repeat (10) tick();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    tick();
    tick();
    resp_ready = 1'b1;

    // Flush in the middle of CALC with a request waiting.
    issue(3'b000, 64'h1234_5678_9ABC_DEF0, 64'd3, 6'd30);
    repeat (20) tick();
    flush     = 1'b1;
    req_valid = 1'b1;
    req_op    = 3'b001;
    req_a     = 64'd55;
    req_b     = 64'd2;
    req_tag   = 6'd31;
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    expq.delete();
    tick();
    issue(3'b001, 64'd100, 64'd7, 6'd32);             wait_idle(200);

    // Reset in the middle of CALC clears the response registers.
    issue(3'b000, -64'd99_999, 64'd13, 6'd40);
    repeat (15) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expq.delete();
    check("midrst_resp_result", resp_result, 64'h0);
    check("midrst_resp_tag",    64'(resp_tag), 64'h0);
    issue(3'b001, 64'd100, 64'd7, 6'd41);             wait_idle(200);
    issue(3'b000, 64'd3, 64'd5, 6'd42);               wait_idle(200);

    // Random traffic with random back-pressure.
    rand_bp = 1'b1;
    for (int n = 0; n < 150; n++) begin
      issue(3'($urandom_range(0, 7)), rand_operand(), rand_operand(), TAG_W'($urandom));
      wait_idle(600);
    end
    rand_bp    = 1'b0;
    resp_ready = 1'b1;
    tick();
    tick();

    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
